// File: rtl/brick_pkg.sv
// brick_pkg: shared colours, FSM encoding and brick geometry defaults for the brick drawer
package brick_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_DONE = 2'd2} state_t;
  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_WHITE  = 3'b111;
  localparam int BRICK_W_DEF = 16;
  localparam int BRICK_H_DEF = 8;
  function automatic logic [2:0] health_colour(input logic [1:0] h);
    return h == 2'd0 ? COL_BLACK : h == 2'd1 ? COL_RED : h == 2'd2 ? COL_YELLOW : COL_GREEN;
  endfunction
endpackage

// File: rtl/brick_colour.sv
// brick_colour: health (plus optional border flag) to 3-bit pixel colour; erased bricks stay black
module brick_colour
  import brick_pkg::*;
(
  input  logic [1:0] health_i,
  input  logic       border_i,
  output logic [2:0] colour_o
);
  assign colour_o = (border_i && health_i != 2'd0) ? COL_WHITE : health_colour(health_i);
endmodule

// File: rtl/brick_drawer.sv
// brick_drawer: rasterises one brick per start into registered VGA plot commands, with a one-entry pending slot.
// Optional macro BRICK_BORDER_EN draws a white outline around bricks with non-zero health.
module brick_drawer
  import brick_pkg::*;
#(
  parameter int BRICK_W = BRICK_W_DEF,
  parameter int BRICK_H = BRICK_H_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic [1:0] health,
  output logic       busy,
  output logic       full,
  output logic       done,
  output logic       overflow,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  output logic [2:0] colour,
  output logic       plot
);
  localparam int PW = $clog2(BRICK_W);
  localparam int PH = $clog2(BRICK_H);
  state_t state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, qx_q, qx_d, qy_q, qy_d;
  logic [1:0] h_q, h_d, qh_q, qh_d;
  logic [PW-1:0] px_q, px_d;
  logic [PH-1:0] py_q, py_d;
  logic pv_q, pv_d, ovf_q, ovf_d;
  logic [9:0] vx_q, vy_q;
  logic [2:0] col_q, col_d;
  logic plot_q;
  logic last_col, last_px, border_d;
  assign last_col = px_q == PW'(BRICK_W - 1);
  assign last_px  = last_col && py_q == PH'(BRICK_H - 1);
`ifdef BRICK_BORDER_EN
  assign border_d = px_d == '0 || px_d == PW'(BRICK_W - 1) || py_d == '0 || py_d == PH'(BRICK_H - 1);
`else
  assign border_d = 1'b0;
`endif
  brick_colour u_colour (.health_i(h_d), .border_i(border_d), .colour_o(col_d));
  // State, active/pending registers and the output registers, which are fed from next-state values so plot aligns with DRAW
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      {x_q, y_q, h_q, px_q, py_q} <= '0;
      {pv_q, qx_q, qy_q, qh_q, ovf_q} <= '0;
      {vx_q, vy_q, col_q, plot_q} <= '0;
    end else begin
      state_q <= state_d;
      {x_q, y_q, h_q, px_q, py_q} <= {x_d, y_d, h_d, px_d, py_d};
      {pv_q, qx_q, qy_q, qh_q, ovf_q} <= {pv_d, qx_d, qy_d, qh_d, ovf_d};
      plot_q <= state_d == S_DRAW;
      if (state_d == S_DRAW) begin
        vx_q  <= x_d + 10'(px_d);
        vy_q  <= y_d + 10'(py_d);
        col_q <= col_d;
      end
    end
  end
  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_DRAW : S_IDLE;
      S_DRAW:  state_d = last_px ? S_DONE : S_DRAW;
      S_DONE:  state_d = (pv_q || start) ? S_DRAW : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // Raster counters, brick loading and pending-slot bookkeeping
  always_comb begin
    {x_d, y_d, h_d, px_d, py_d} = {x_q, y_q, h_q, px_q, py_q};
    {pv_d, qx_d, qy_d, qh_d, ovf_d} = {pv_q, qx_q, qy_q, qh_q, ovf_q};
    case (state_q)
      S_IDLE: if (start) {x_d, y_d, h_d, px_d, py_d} = {x_in, y_in, health, PW'(0), PH'(0)};
      S_DRAW: begin
        px_d = last_col ? '0 : px_q + PW'(1);
        py_d = last_col ? py_q + PH'(1) : py_q;
        ovf_d = ovf_q | (start & pv_q);
        if (start && !pv_q) {pv_d, qx_d, qy_d, qh_d} = {1'b1, x_in, y_in, health};
      end
      S_DONE: begin
        {px_d, py_d} = '0;
        if (pv_q) {x_d, y_d, h_d, pv_d} = {qx_q, qy_q, qh_q, start};
        else if (start) {x_d, y_d, h_d} = {x_in, y_in, health};
        if (pv_q && start) {qx_d, qy_d, qh_d} = {x_in, y_in, health};
      end
      default: ;
    endcase
  end
  // Status outputs decoded from state
  always_comb begin
    busy = state_q != S_IDLE;
    done = state_q == S_DONE;
  end
  assign full     = pv_q;
  assign overflow = ovf_q;
  assign vga_x    = vx_q;
  assign vga_y    = vy_q;
  assign colour   = col_q;
  assign plot     = plot_q;
endmodule

// File: doc/brick_drawer.md
# brick_drawer

Downstream consumer of the level loader. Takes one brick descriptor (top-left pixel, health) per `start` pulse and rasterises it into a stream of single-pixel plot commands for the VGA adapter, with colour chosen by health. Health 0 erases the brick by drawing it in black. A one-entry pending buffer lets the loader issue the next brick while the current one is still drawing.

## Interface
- `BRICK_W`, default 16: brick width in pixels, from 2 to 64.
- `BRICK_H`, default 8: brick height in pixels, from 2 to 64.
- `clk`  in  1  system clock
- `resetn`  in  1  reset, synchronous, active-low; clock `clk`
- `start`  in  1  draw request, sampled on every rising edge
- `x_in`  in  10  brick top-left x, captured with `start`
- `y_in`  in  10  brick top-left y, captured with `start`
- `health`  in  2  brick health, captured with `start`
- `busy`  out  1  high whenever the state is not IDLE
- `full`  out  1  pending buffer occupied
- `done`  out  1  one-cycle pulse after the last pixel of a brick
- `overflow`  out  1  sticky; set when a request is dropped
- `vga_x`  out  10  pixel x, registered
- `vga_y`  out  10  pixel y, registered
- `colour`  out  3  pixel colour, registered
- `plot`  out  1  pixel write strobe, registered

## Operation
- **States.** IDLE, DRAW, DONE.
- **IDLE.**
  - On `start`, latch `x_in`, `y_in` and `health` into the active registers.
  - Clear `px` and `py`, then go to DRAW.
- **DRAW.**
  - Each cycle, drive `plot`=1, `vga_x` = x_lat+`px` and `vga_y` = y_lat+`py`.
  - `vga_x` and `vga_y` are 10-bit sums that wrap modulo 1024. There is no clipping.
  - Pixel order is raster: `px` runs 0..`BRICK_W`-1, then `py` increments.
  - After pixel (`BRICK_W`-1, `BRICK_H`-1), go to DONE.
- **Colour map.**
  - Health 0 → 3'b000.
  - Health 1 → 3'b100.
  - Health 2 → 3'b110.
  - Health 3 → 3'b010.
- **DONE.**
  - `done`=1 and `plot`=0.
  - If the pending buffer is valid, load it into the active registers and go to DRAW.
  - Else if `start` is high, load the inputs directly and go to DRAW.
  - Else go to IDLE.
- **Pending buffer.**
  - `start` in DRAW, or in DONE with pending valid, writes the pending slot if it is empty.
  - If the slot is already full, the request is dropped and `overflow` is set.
  - Simultaneous events in DONE with pending valid and `start` high: pending moves to active, and the new request fills the freed slot. Nothing is dropped.
- **`overflow`.** Cleared only by reset.

## Timing
- **Reset values.** State IDLE, pending empty. Every output is 0: `busy`, `full`, `done`, `overflow`, `vga_x`, `vga_y`, `colour`, `plot`.
- **Reset mid-draw.** Aborts the brick on the next edge. No `done` pulse, and the pending entry is discarded.
- **Latency.** `start` at edge t gives the first `plot` in cycle t+1. `plot` stays high for exactly `BRICK_W`×`BRICK_H` consecutive cycles. `done` follows in the next cycle.
- **Back-to-back bricks.** A pending brick starts plotting in the cycle after `done`. That is one dead cycle between bricks.
- **`busy`.** Combinational from state: high in DRAW and DONE.
- **`full`.** Registered.
- **Outputs.** `vga_x`, `vga_y`, `colour` and `plot` are all registered. They hold their last values with `plot`=0 outside DRAW.

## Configuration
- Macro `BRICK_BORDER_EN`.
- **Defined.** For health ≠ 0, pixels with `px`==0, `px`==`BRICK_W`-1, `py`==0 or `py`==`BRICK_H`-1 are drawn 3'b111. Interior pixels use the colour map.
- **Defined, health 0.** The whole rectangle is black.
- **Undefined.** Every pixel uses the colour map. No border logic is synthesised.

## Structure
- **Package `brick_pkg`.**
  - Colour constants: `COL_BLACK`, `COL_RED`, `COL_YELLOW`, `COL_GREEN`, `COL_WHITE`.
  - The 2-bit state encoding.
  - Default `BRICK_W` and `BRICK_H`, shared with the loader's draw-delay constant.
- **Sub-module `brick_colour`.**
  - Combinational map from health and the border flag to a 3-bit colour.
  - Reused by the collision/erase path.
- **Top level.** FSM, `px`/`py` counters, active and pending registers, output registers.

## Test plan
- **Single brick.** `start` with x=100, y=40, health=3, W=16, H=8.
  - 128 consecutive `plot` cycles.
  - First pixel (100,40), last pixel (115,47), colour 3'b010 (interior pixels when `BRICK_BORDER_EN` is set).
  - `done` pulses in cycle t+129.
- **Erase.** Health=0 → all 128 pixels have colour 3'b000, including the border when `BRICK_BORDER_EN` is set.
- **Queueing and overflow.**
  - Second `start` during DRAW → `full`=1, and the second brick starts plotting in the cycle after the first `done`.
  - Third `start` while `full` → `overflow`=1, and the third brick is never plotted.
- **Wrap-around.** x=1020 → `vga_x` sequence 1020..1023, 0..11.
- **Reset mid-operation.** Reset at pixel 50 with pending full → next cycle all outputs 0 and `full`=0, with no `done`.
- **Simultaneous events.** `start` in DONE with pending valid → pending brick is drawn, new brick is buffered, `overflow` stays 0.
